audio_tone_monitor: RTL and testbench

Synthesizable multi-channel tone checker for the equalizer audio path. It watches decoded codec output samples and, per channel, finds negative-to-positive zero crossings. At each crossing it measures the period in samples and the positive peak amplitude, and counts the periods and peaks that fall outside programmed windows. It sits beside the codec receive path for on-chip self-test of filter bands and volume, replacing bench-only checking with a reusable block.

---
 rtl/tone_mon_pkg.sv | 13 +
 rtl/tone_chan_mon.sv | 117 +++++++++++
 rtl/audio_tone_monitor.sv | 59 +++++
 tb/tb_audio_tone_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tone_mon_pkg.sv
// Shared types and helpers for the audio tone monitor.
package tone_mon_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} chan_state_e;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/tone_chan_mon.sv
// One channel: zero-crossing detector, period/peak tracking, window checks
// and the IDLE/SETTLE/MEASURE/DONE sequencer.
module tone_chan_mon
  import tone_mon_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smpl_vld,
  input  logic [WIDTH-1:0] smpl,
  input  logic [CNT_W-1:0] settle_xings,
  input  logic [CNT_W-1:0] test_len,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  input  logic [WIDTH-1:0] min_ampl,
  input  logic [WIDTH-1:0] max_ampl,
  output logic             active,
  output logic             finished,
  output logic [ERR_W-1:0] freq_err,
  output logic [ERR_W-1:0] ampl_err,
  output logic [CNT_W-1:0] last_period,
  output logic [WIDTH-1:0] last_peak
);

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] period_cnt, settle_cnt, len_cnt, period;
  logic [CNT_W:0]   settle_nxt, len_nxt;
  logic [WIDTH-1:0] peak, peak_m;
  logic             prev_msb, tmo;
  logic             go, proc, meas, xing, per_bad, amp_bad;
  logic             tmo_hit, f_inc, a_inc, settle_done, len_done;

  assign active   = (state == SETTLE) || (state == MEASURE);
  assign finished = (state == DONE);
  assign go       = start && !active;
  assign proc     = smpl_vld && active;
  assign meas     = proc && (state == MEASURE);
  assign xing     = prev_msb && !smpl[WIDTH-1];

  // Period including the current sample; saturates with period_cnt.
  assign period  = CNT_W'(sat_inc(32'(period_cnt), CNT_W));
  assign peak_m  = ($signed(smpl) > $signed(peak)) ? smpl : peak;
  assign per_bad = (period < min_period) || (period > max_period);
  assign amp_bad = ($signed(peak_m) < $signed(min_ampl)) ||
                   ($signed(peak_m) > $signed(max_ampl));

  // A long gap is charged once; the late crossing that ends it is not.
  assign tmo_hit = meas && !xing && !tmo && (period > max_period);
  assign f_inc   = (meas && xing && per_bad && !tmo) || tmo_hit;
  assign a_inc   = meas && xing && amp_bad;

  assign settle_nxt  = {1'b0, settle_cnt} + 1'b1;
  assign len_nxt     = {1'b0, len_cnt} + 1'b1;
  assign settle_done = (settle_xings == '0) ||
                       (xing && (settle_nxt >= {1'b0, settle_xings}));
  assign len_done    = len_nxt >= {1'b0, test_len};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (smpl_vld && settle_done) state_nxt = MEASURE;
      MEASURE: begin
        if (test_len == '0)             state_nxt = DONE;
        else if (smpl_vld && len_done)  state_nxt = DONE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || go) begin
      period_cnt  <= '0;
      settle_cnt  <= '0;
      len_cnt     <= '0;
      peak        <= '0;
      prev_msb    <= 1'b0;
      tmo         <= 1'b0;
      freq_err    <= '0;
      ampl_err    <= '0;
      last_period <= '0;
      last_peak   <= '0;
    end else if (proc) begin
      prev_msb <= smpl[WIDTH-1];
      if (xing) begin
        period_cnt <= '0;
        peak       <= '0;
        if (state == SETTLE) settle_cnt <= settle_nxt[CNT_W-1:0];
      end else begin
        period_cnt <= period;
        peak       <= peak_m;
      end
      if (state == MEASURE) begin
        len_cnt <= len_nxt[CNT_W-1:0];
        if (f_inc) freq_err <= ERR_W'(sat_inc(32'(freq_err), ERR_W));
        if (a_inc) ampl_err <= ERR_W'(sat_inc(32'(ampl_err), ERR_W));
        if (xing) begin
          last_period <= period;
          last_peak   <= peak_m;
          tmo         <= 1'b0;
        end else if (tmo_hit) begin
          tmo <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_tone_monitor.sv
// Multi-channel tone checker: one tone_chan_mon per channel, with test
// status aggregated across channels.
module audio_tone_monitor #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 16,
  parameter int ERR_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      smpl_vld,
  input  logic [CHANNELS*WIDTH-1:0] smpl,
  input  logic [CNT_W-1:0]          settle_xings,
  input  logic [CNT_W-1:0]          test_len,
  input  logic [CNT_W-1:0]          min_period,
  input  logic [CNT_W-1:0]          max_period,
  input  logic [WIDTH-1:0]          min_ampl,
  input  logic [WIDTH-1:0]          max_ampl,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS*ERR_W-1:0] freq_err,
  output logic [CHANNELS*ERR_W-1:0] ampl_err,
  output logic [CHANNELS*CNT_W-1:0] last_period,
  output logic [CHANNELS*WIDTH-1:0] last_peak
);

  logic [CHANNELS-1:0] chan_active, chan_done;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tone_chan_mon #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .ERR_W (ERR_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .smpl_vld     (smpl_vld),
      .smpl         (smpl[c*WIDTH +: WIDTH]),
      .settle_xings (settle_xings),
      .test_len     (test_len),
      .min_period   (min_period),
      .max_period   (max_period),
      .min_ampl     (min_ampl),
      .max_ampl     (max_ampl),
      .active       (chan_active[c]),
      .finished     (chan_done[c]),
      .freq_err     (freq_err[c*ERR_W +: ERR_W]),
      .ampl_err     (ampl_err[c*ERR_W +: ERR_W]),
      .last_period  (last_period[c*CNT_W +: CNT_W]),
      .last_peak    (last_peak[c*WIDTH +: WIDTH])
    );
  end

  assign busy = |chan_active;
  assign done = &chan_done;

endmodule

// File: tb/tb_audio_tone_monitor.sv
// Bench for audio_tone_monitor: sine stimulus, table of expected results,
// plus hand sequences for reset, zero-length test and mid-test reset.
module tb_audio_tone_monitor;

  localparam int CH = 2;
  localparam int W  = 16;
  localparam int CW = 16;
  localparam int EW = 16;

  logic            clk = 1'b0;
  logic            rst, start, smpl_vld;
  logic [CH*W-1:0] smpl;
  logic [CW-1:0]   settle_xings, test_len, min_period, max_period;
  logic [W-1:0]    min_ampl, max_ampl;
  logic            busy, done, busy4, done4;
  logic [CH*EW-1:0] freq_err, ampl_err;
  logic [CH*4-1:0]  freq_err4, ampl_err4;
  logic [CH*CW-1:0] last_period, last_period4;
  logic [CH*W-1:0]  last_peak, last_peak4;

  always #5 clk = ~clk;

  audio_tone_monitor #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .smpl_vld(smpl_vld), .smpl(smpl),
    .settle_xings(settle_xings), .test_len(test_len),
    .min_period(min_period), .max_period(max_period),
    .min_ampl(min_ampl), .max_ampl(max_ampl),
    .busy(busy), .done(done), .freq_err(freq_err), .ampl_err(ampl_err),
    .last_period(last_period), .last_peak(last_peak));

  // Narrow error counters to exercise saturation on the same stimulus.
  audio_tone_monitor #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .smpl_vld(smpl_vld), .smpl(smpl),
    .settle_xings(settle_xings), .test_len(test_len),
    .min_period(min_period), .max_period(max_period),
    .min_ampl(min_ampl), .max_ampl(max_ampl),
    .busy(busy4), .done(done4), .freq_err(freq_err4), .ampl_err(ampl_err4),
    .last_period(last_period4), .last_peak(last_peak4));

  typedef struct {
    int period; int amp0; int amp1; bit drop; int last_idx;
    int f0; int a0; int f1; int a1; int lp;
  } vec_t;

  typedef struct {
    int f0; int a0; int f1; int a1; int lp; int pk0; int pk1; int s0; int s1;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int tone(input int n, input int p, input int a);
    real x;
    x = a * $sin(2.0 * 3.14159265358979 * (n % p) / p);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Channel 0 of a dropout vector sits at +100 for 300 samples mid-measure.
  function automatic int samp(input vec_t v, input int ch, input int n);
    if (v.drop && ch == 0 && n >= 1010 && n < 1310) return 100;
    return tone(n, v.period, (ch == 0) ? v.amp0 : v.amp1);
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    smpl_vld = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic compare_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("freq_err0", freq_err[0 +: EW], e.f0);
    chk("ampl_err0", ampl_err[0 +: EW], e.a0);
    chk("freq_err1", freq_err[EW +: EW], e.f1);
    chk("ampl_err1", ampl_err[EW +: EW], e.a1);
    chk("last_period0", last_period[0 +: CW], e.lp);
    chk("last_period1", last_period[CW +: CW], e.lp);
    chk("last_peak0", last_peak[0 +: W], e.pk0);
    chk("last_peak1", last_peak[W +: W], e.pk1);
    chk("sat_freq_err0", freq_err4[0 +: 4], e.s0);
    chk("sat_freq_err1", freq_err4[4 +: 4], e.s1);
  endtask

  task automatic run_vec(input vec_t v, input int abort_at);
    exp_t e;
    pulse_start();
    if (abort_at < 0) begin
      e = '{v.f0, v.a0, v.f1, v.a1, v.lp, v.amp0, v.amp1, sat15(v.f0), sat15(v.f1)};
      sb.push_back(e);
    end
    for (int n = 0; n <= v.last_idx; n++) begin
      if (n == abort_at) return;
      if ($urandom_range(3) == 0) begin
        smpl_vld = 1'b0;
        @(negedge clk);
      end
      smpl_vld = 1'b1;
      smpl = {16'(samp(v, 1, n)), 16'(samp(v, 0, n))};
      if (n == v.last_idx) chk("done_before_last", done, 0);
      @(negedge clk);
    end
    smpl_vld = 1'b0;
    chk("done_after_last", done, 1);
    chk("busy_after_last", busy, 0);
    compare_result();
  endtask

  initial begin
    // period amp0 amp1 drop last_idx | f0 a0 f1 a1 last_period
    vecs[0] = '{48, 1000, 1000, 1'b0, 2480,  0, 0,  0,  0, 48};  // clean
    vecs[1] = '{48, 1000, 1500, 1'b0, 2480,  0, 0,  0, 41, 48};  // loud ch1
    vecs[2] = '{24, 1000, 1000, 1'b0, 2240, 83, 0, 83,  0, 24};  // wrong band
    vecs[3] = '{48, 1000, 1000, 1'b1, 2480,  1, 0,  0,  0, 48};  // dropout ch0

    rst = 1'b1; start = 1'b0; smpl_vld = 1'b0; smpl = '0;
    settle_xings = 16'd0; test_len = 16'd0;
    min_period = 16'd40; max_period = 16'd56;
    min_ampl = 16'd750; max_ampl = 16'd1250;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_freq_err", freq_err, 0);
    chk("rst_ampl_err", ampl_err, 0);
    chk("rst_last_period", last_period, 0);
    chk("rst_last_peak", last_peak, 0);
    rst = 1'b0;

    // settle_xings=0 measures from the first sample; test_len=0 ends next cycle
    pulse_start();
    smpl_vld = 1'b1;
    smpl = {16'(-5), 16'(-5)};
    @(negedge clk);
    smpl_vld = 1'b0;
    chk("zero_len_busy", busy, 1);
    chk("zero_len_done_early", done, 0);
    @(negedge clk);
    chk("zero_len_done", done, 1);
    chk("zero_len_busy_fall", busy, 0);
    chk("zero_len_freq_err", freq_err, 0);

    settle_xings = 16'd10;
    test_len = 16'd2000;
    for (int i = 0; i < 4; i++) run_vec(vecs[i], -1);

    // Reset in the middle of MEASURE, then a clean rerun
    run_vec(vecs[0], 800);
    smpl_vld = 1'b0;
    chk("pre_reset_period", last_period[0 +: CW], 48);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_last_period", last_period, 0);
    chk("midrst_last_peak", last_peak, 0);
    chk("midrst_errs", freq_err | ampl_err, 0);
    run_vec(vecs[0], -1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
